// File: rtl/alu_mdu.sv
// Iterative RISC-V M-extension multiply/divide unit: one product or quotient bit per cycle,
// valid/ready handshake on both sides, flush to abandon the operation in flight.
module alu_mdu #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_zero,
    output logic                  o_neg,
    output logic                  o_div_zero
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [2:0]           op_q;
    logic                 neg_q;
    logic [2*W-1:0]       acc_q, mcand_q;
    logic [W-1:0]         mplier_q;

    logic                 accept;
    logic                 is_div_in, a_signed, b_signed, a_neg, b_neg;
    logic [W-1:0]         a_mag, b_mag;
    logic                 div_zero_in, ovf_in, special_in;
    logic [W-1:0]         special_res;

    logic [W:0]           rem_sh, rem_diff;
    logic [2*W-1:0]       mul_step, div_step, acc_step, mul_prod;
    logic [W-1:0]         div_val, div_res, final_res;

    assign o_ready = (state_q == IDLE) && !i_rst;
    assign o_valid = (state_q == DONE);
    assign o_zero  = (o_res == '0);
    assign o_neg   = o_res[W-1];
    assign accept  = i_valid && o_ready && !i_flush;

    // Operand decode: signedness per op, magnitudes, and the two results that need no iteration.
    always_comb begin
        is_div_in   = i_op[2];
        a_signed    = is_div_in ? !i_op[0] : (i_op != OP_MULHU);
        b_signed    = is_div_in ? !i_op[0] : (i_op == OP_MUL || i_op == OP_MULH);
        a_neg       = a_signed && i_rs1_data[W-1];
        b_neg       = b_signed && i_rs2_data[W-1];
        a_mag       = a_neg ? -i_rs1_data : i_rs1_data;
        b_mag       = b_neg ? -i_rs2_data : i_rs2_data;
        div_zero_in = is_div_in && (i_rs2_data == '0);
        ovf_in      = is_div_in && !i_op[0] && (i_rs1_data == {1'b1, {(W-1){1'b0}}})
                      && (i_rs2_data == '1);
        special_in  = div_zero_in || ovf_in;
        special_res = '0;
        if (div_zero_in) begin
            special_res = i_op[1] ? i_rs1_data : '1;
        end else if (ovf_in) begin
            special_res = i_op[1] ? '0 : i_rs1_data;
        end
    end

    // One iteration: shift-add for multiply, restoring subtract for divide (remainder in the
    // high half of acc_q, dividend/quotient in the low half, divisor in mplier_q).
    always_comb begin
        rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
        rem_diff = rem_sh - {1'b0, mplier_q};
        mul_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        div_step = rem_diff[W] ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                               : {rem_diff[W-1:0], acc_q[W-2:0], 1'b1};
        acc_step = op_q[2] ? div_step : mul_step;
        mul_prod = neg_q ? -mul_step : mul_step;
        div_val  = op_q[1] ? div_step[2*W-1:W] : div_step[W-1:0];
        div_res  = neg_q ? -div_val : div_val;
        if (op_q[2]) begin
            final_res = div_res;
        end else if (op_q == OP_MUL) begin
            final_res = mul_prod[W-1:0];
        end else begin
            final_res = mul_prod[2*W-1:W];
        end
    end

    // NOTE: every combinational output gets a default before the case, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = special_in ? DONE : CALC;
            CALC: begin
                if (i_flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: if (i_flush || i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            o_res      <= '0;
            o_div_zero <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q       <= i_op;
                neg_q      <= (is_div_in && i_op[1]) ? a_neg : (a_neg ^ b_neg);
                acc_q      <= is_div_in ? {{W{1'b0}}, a_mag} : '0;
                mcand_q    <= {{W{1'b0}}, a_mag};
                mplier_q   <= b_mag;
                cnt_q      <= CNT_WIDTH'(W);
                o_div_zero <= div_zero_in;
                if (special_in) o_res <= special_res;
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q - CNT_WIDTH'(1);
                acc_q <= acc_step;
                if (!op_q[2]) begin
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                end
                if (cnt_q == CNT_WIDTH'(1) && !i_flush) o_res <= final_res;
            end
        end
    end

endmodule
